// File: rtl/led_pkg.sv
// Shared types and constants for the LED strip link: 24-bit word layout,
// pad nibble value and the receiver state encoding.
package led_pkg;

    localparam int BITS_PER_LED = 24;
    localparam logic [3:0] PAD_NIBBLE = 4'hF;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] pad0;
        logic [3:0] g;
        logic [3:0] pad1;
        logic [3:0] b;
        logic [3:0] pad2;
    } led_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } rx_state_t;

    // True when any filler nibble of the word differs from the pad value.
    function automatic logic pad_bad(input led_word_t w);
        return (w.pad0 != PAD_NIBBLE) || (w.pad1 != PAD_NIBBLE) || (w.pad2 != PAD_NIBBLE);
    endfunction

endpackage

// File: rtl/led_sig_sync.sv
// Brings the asynchronous cko/sdo pair into the clk domain through matched
// flop chains and flags cko rising edges on the synchronized copy.
module led_sig_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic cko_i,
    input  logic sdo_i,
    output logic sdo_s,
    output logic cko_rise
);

    logic [SYNC_STAGES-1:0] cko_sync_q, cko_sync_d;
    logic [SYNC_STAGES-1:0] sdo_sync_q, sdo_sync_d;
    logic                   cko_prev_q, cko_prev_d;

    // Identical depth on both chains keeps sdo aligned to its cko edge.
    always_comb begin
        cko_sync_d = {cko_sync_q[SYNC_STAGES-2:0], cko_i};
        sdo_sync_d = {sdo_sync_q[SYNC_STAGES-2:0], sdo_i};
        cko_prev_d = cko_sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cko_sync_q <= '0;
            sdo_sync_q <= '0;
            cko_prev_q <= 1'b0;
        end else begin
            cko_sync_q <= cko_sync_d;
            sdo_sync_q <= sdo_sync_d;
            cko_prev_q <= cko_prev_d;
        end
    end

    assign sdo_s    = sdo_sync_q[SYNC_STAGES-1];
    assign cko_rise = cko_sync_q[SYNC_STAGES-1] & ~cko_prev_q;

endmodule

// File: rtl/led_frame_rx.sv
// LED link receiver: deserializes 24-bit LED words from the synchronized
// cko/sdo pair, strobes each pixel and summarizes the frame on idle timeout.
module led_frame_rx
    import led_pkg::*;
#(
    parameter int LED_NUM     = 47,
    parameter int IDLE_CYC    = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       enable,
    input  logic                       cko_i,
    input  logic                       sdo_i,
    output logic                       pix_valid,
    output logic [$clog2(LED_NUM)-1:0] pix_idx,
    output logic [3:0]                 pix_r,
    output logic [3:0]                 pix_g,
    output logic [3:0]                 pix_b,
    output logic                       pix_pad_err,
    output logic                       frame_done,
    output logic                       frame_err,
    output logic                       busy,
    output rx_state_t                  dbg_state
);

    localparam int IDX_W  = $clog2(LED_NUM);
    localparam int CNT_W  = $clog2(LED_NUM + 2);
    localparam int IDLE_W = $clog2(IDLE_CYC);
    localparam int BW     = BITS_PER_LED;

    localparam logic [CNT_W-1:0]  LED_NUM_C  = CNT_W'(LED_NUM);
    localparam logic [CNT_W-1:0]  WORD_SAT_C = CNT_W'(LED_NUM + 1);
    localparam logic [4:0]        LAST_BIT_C = 5'(BW - 1);
    localparam logic [IDLE_W-1:0] IDLE_TO_C  = IDLE_W'(IDLE_CYC - 1);

    logic sdo_s;
    logic cko_rise;

    led_sig_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rstn     (rstn),
        .cko_i    (cko_i),
        .sdo_i    (sdo_i),
        .sdo_s    (sdo_s),
        .cko_rise (cko_rise)
    );

    rx_state_t         state_q, state_d;
    logic [BW-1:0]     shift_q, shift_d;
    logic [4:0]        bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              ovf_q, ovf_d;
    logic              pix_valid_q, pix_valid_d;
    logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
    logic [3:0]        pix_r_q, pix_r_d;
    logic [3:0]        pix_g_q, pix_g_d;
    logic [3:0]        pix_b_q, pix_b_d;
    logic              pix_pad_err_q, pix_pad_err_d;
    logic              frame_done_q, frame_done_d;
    logic              frame_err_q, frame_err_d;
    led_word_t         word_next;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        idle_cnt_d    = idle_cnt_q;
        ovf_d         = ovf_q;
        pix_valid_d   = 1'b0;
        pix_idx_d     = pix_idx_q;
        pix_r_d       = pix_r_q;
        pix_g_d       = pix_g_q;
        pix_b_d       = pix_b_q;
        pix_pad_err_d = pix_pad_err_q;
        frame_done_d  = 1'b0;
        frame_err_d   = 1'b0;
        word_next     = (shift_q << 1) | BW'(sdo_s);

        if (!enable) begin
            // Abort: drop any partial word, no frame summary.
            state_d    = IDLE;
            shift_d    = '0;
            bit_cnt_d  = '0;
            word_cnt_d = '0;
            idle_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cko_rise) begin
                        state_d    = RECV;
                        shift_d    = BW'(sdo_s);
                        bit_cnt_d  = 5'd1;
                        word_cnt_d = '0;
                        idle_cnt_d = '0;
                        ovf_d      = 1'b0;
                    end
                end
                RECV: begin
                    // An edge always beats a coincident idle timeout.
                    if (cko_rise) begin
                        shift_d    = word_next;
                        idle_cnt_d = '0;
                        if (bit_cnt_q == LAST_BIT_C) begin
                            bit_cnt_d = '0;
                            if (word_cnt_q < LED_NUM_C) begin
                                pix_valid_d   = 1'b1;
                                pix_idx_d     = word_cnt_q[IDX_W-1:0];
                                pix_r_d       = word_next.r;
                                pix_g_d       = word_next.g;
                                pix_b_d       = word_next.b;
                                pix_pad_err_d = pad_bad(word_next);
                            end else begin
                                ovf_d = 1'b1;
                            end
                            if (word_cnt_q < WORD_SAT_C) begin
                                word_cnt_d = word_cnt_q + 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end else if (idle_cnt_q == IDLE_TO_C) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                        frame_err_d  = (word_cnt_q != LED_NUM_C) || (bit_cnt_q != 5'd0) || ovf_q;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    // Edges arriving here are deliberately dropped.
                    state_d    = IDLE;
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    idle_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
            idle_cnt_q    <= '0;
            ovf_q         <= 1'b0;
            pix_valid_q   <= 1'b0;
            pix_idx_q     <= '0;
            pix_r_q       <= '0;
            pix_g_q       <= '0;
            pix_b_q       <= '0;
            pix_pad_err_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            idle_cnt_q    <= idle_cnt_d;
            ovf_q         <= ovf_d;
            pix_valid_q   <= pix_valid_d;
            pix_idx_q     <= pix_idx_d;
            pix_r_q       <= pix_r_d;
            pix_g_q       <= pix_g_d;
            pix_b_q       <= pix_b_d;
            pix_pad_err_q <= pix_pad_err_d;
            frame_done_q  <= frame_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Strobes are masked combinationally so a disable silences them at once.
    assign pix_valid   = pix_valid_q & enable;
    assign pix_idx     = pix_idx_q;
    assign pix_r       = pix_r_q;
    assign pix_g       = pix_g_q;
    assign pix_b       = pix_b_q;
    assign pix_pad_err = pix_pad_err_q;
    assign frame_done  = frame_done_q & enable;
    assign frame_err   = frame_err_q & enable;
    assign busy        = (state_q == RECV);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_led_frame_rx.sv
// Bench for led_frame_rx: serial frames driven on cko/sdo, expected pixels and
// frame summaries queued from a word-level model and matched by a monitor.
module tb_led_frame_rx;
    import led_pkg::*;

    localparam int LED_NUM     = 47;
    localparam int IDLE_CYC    = 64;
    localparam int SYNC_STAGES = 2;
    localparam int IDX_W       = $clog2(LED_NUM);

    logic             clk = 1'b0;
    logic             rstn;
    logic             enable;
    logic             cko_i;
    logic             sdo_i;
    logic             pix_valid;
    logic [IDX_W-1:0] pix_idx;
    logic [3:0]       pix_r, pix_g, pix_b;
    logic             pix_pad_err;
    logic             frame_done;
    logic             frame_err;
    logic             busy;
    rx_state_t        dbg_state;

    led_frame_rx #(
        .LED_NUM     (LED_NUM),
        .IDLE_CYC    (IDLE_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .cko_i       (cko_i),
        .sdo_i       (sdo_i),
        .pix_valid   (pix_valid),
        .pix_idx     (pix_idx),
        .pix_r       (pix_r),
        .pix_g       (pix_g),
        .pix_b       (pix_b),
        .pix_pad_err (pix_pad_err),
        .frame_done  (frame_done),
        .frame_err   (frame_err),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [18:0] pix_exp_q[$];
    logic        frm_exp_q[$];
    logic [23:0] words[$];
    int          last_hi = 2;
    bit          fixed_timing = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [18:0] mon_pix;
    logic        mon_frm;

    always @(negedge clk) begin
        if (rstn) begin
            if (pix_valid) begin
                if (pix_exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pix_unexpected: got idx %0d r %0h g %0h b %0h required no pixel",
                             pix_idx, pix_r, pix_g, pix_b);
                end else begin
                    mon_pix = pix_exp_q.pop_front();
                    check("pixel", {13'd0, pix_idx, pix_r, pix_g, pix_b, pix_pad_err}, {13'd0, mon_pix});
                end
            end
            if (frame_done) begin
                if (frm_exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL frame_unexpected: got frame_done err %0b required no frame_done", frame_err);
                end else begin
                    mon_frm = frm_exp_q.pop_front();
                    check("frame_err", {31'd0, frame_err}, {31'd0, mon_frm});
                end
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [18:0] pixel_of(input int idx, input logic [23:0] w);
        logic pe;
        pe = (w[19:16] != 4'hF) || (w[11:8] != 4'hF) || (w[3:0] != 4'hF);
        return {IDX_W'(idx), w[23:20], w[15:12], w[7:4], pe};
    endfunction

    task automatic expect_pixels(input int n);
        for (int i = 0; i < n && i < LED_NUM; i++) pix_exp_q.push_back(pixel_of(i, words[i]));
    endtask

    task automatic fill_nominal(input int n);
        logic [3:0] k4;
        words.delete();
        for (int k = 0; k < n; k++) begin
            k4 = k[3:0];
            words.push_back({k4, 4'hF, ~k4, 4'hF, 4'h5, 4'hF});
        end
    endtask

    task automatic fill_random(input int n);
        logic [23:0] w;
        words.delete();
        for (int k = 0; k < n; k++) begin
            w = {$urandom_range(0, 15) & 4'hF, 4'hF, $urandom_range(0, 15) & 4'hF, 4'hF,
                 $urandom_range(0, 15) & 4'hF, 4'hF};
            if ($urandom_range(0, 7) == 0) w[11:8] = 4'($urandom_range(0, 15));
            words.push_back(w);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_bit(input logic b, input int lo, input int hi);
        cko_i = 1'b0;
        sdo_i = b;
        step(lo);
        cko_i = 1'b1;
        step(hi);
        last_hi = hi;
    endtask

    task automatic send_word(input logic [23:0] w, input int nbits, input bit gap);
        int lo;
        int hi;
        for (int i = 0; i < nbits; i++) begin
            lo = fixed_timing ? 2 : $urandom_range(2, 3);
            hi = fixed_timing ? 3 : $urandom_range(2, 3);
            if (gap && i == 0) lo = IDLE_CYC - last_hi;
            send_bit(w[23-i], lo, hi);
        end
    endtask

    // Sends words[0..n-1] plus extra loose bits, then idles long enough to close.
    task automatic run_frame(input int n, input int extra, input int gap_word);
        expect_pixels(n);
        frm_exp_q.push_back((n != LED_NUM) || (extra != 0));
        for (int i = 0; i < n; i++) begin
            send_word(words[i], 24, i == gap_word);
            if (i == 0) check("busy_recv", {31'd0, busy}, 32'd1);
        end
        if (extra > 0) send_word(24'($urandom), extra, 1'b0);
        cko_i = 1'b0;
        step(100);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
        check({tag, "_pix_idx"}, {26'd0, pix_idx}, 32'd0);
        check({tag, "_pix_rgb"}, {20'd0, pix_r, pix_g, pix_b}, 32'd0);
        check({tag, "_pix_pad_err"}, {31'd0, pix_pad_err}, 32'd0);
        check({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        rstn   = 1'b0;
        enable = 1'b1;
        cko_i  = 1'b0;
        sdo_i  = 1'b0;
        step(3);
        check_all_zero("reset");
        check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
        rstn = 1'b1;
        step(5);

        fixed_timing = 1'b1;
        fill_nominal(47);
        run_frame(47, 0, -1);
        fixed_timing = 1'b0;

        fill_random(10);
        run_frame(10, 0, -1);

        fill_random(48);
        run_frame(48, 0, -1);

        fill_random(47);
        words[3] = 24'hA0CF5F;
        run_frame(47, 0, -1);

        fill_random(47);
        run_frame(47, 7, -1);

        fill_random(47);
        run_frame(47, 0, -1);

        // Enable drop partway through word 20.
        fill_random(47);
        expect_pixels(20);
        for (int i = 0; i < 20; i++) send_word(words[i], 24, 1'b0);
        send_word(words[20], 12, 1'b0);
        enable = 1'b0;
        step(2);
        check("disable_busy", {31'd0, busy}, 32'd0);
        check("disable_state", {30'd0, dbg_state}, {30'd0, IDLE});
        cko_i = 1'b0;
        step(100);
        enable = 1'b1;
        step(5);
        fill_random(47);
        run_frame(47, 0, -1);

        // Reset in the middle of word 5.
        fill_random(47);
        expect_pixels(5);
        for (int i = 0; i < 5; i++) send_word(words[i], 24, 1'b0);
        send_word(words[5], 6, 1'b0);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        cko_i = 1'b0;
        sdo_i = 1'b0;
        rstn  = 1'b0;
        #1;
        check_all_zero("midreset");
        step(3);
        rstn = 1'b1;
        step(5);

        // Gap of exactly IDLE_CYC clk before word 30: edge meets timeout.
        fill_random(47);
        run_frame(47, 0, 30);

        budget = 0;
        while ((pix_exp_q.size() != 0 || frm_exp_q.size() != 0) && budget < 500) begin
            step(1);
            budget++;
        end
        check("pix_queue_drained", pix_exp_q.size(), 32'd0);
        check("frame_queue_drained", frm_exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
